// File: rtl/cpu_timing_pkg.sv
// Shared timing types and defaults for the power/clock sequencer.
// State encoding, default timing constants and a counter-width helper.
package cpu_timing_pkg;

    typedef enum logic [1:0] {
        ST_POR   = 2'd0,
        ST_RUN   = 2'd1,
        ST_MCLR  = 2'd2,
        ST_PFAIL = 2'd3
    } state_e;

    localparam int DEF_POR_CYCLES  = 1000;
    localparam int DEF_MCL_MIN     = 16;
    localparam int DEF_FILT_CYCLES = 8;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_prescaler.sv
// One prescaler channel: wrap counter with a registered one-cycle tick.
// A zero divisor parks the channel (counter 0, no ticks).
module clk_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             ev_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             wrap;

    // >= so a divisor lowered below the count wraps on the next event
    assign wrap = (cnt_q >= (div_i - DIV_W'(1)));

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr_i || (div_i == '0)) begin
            cnt_d = '0;
        end else if (ev_i) begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/power_clk_seq.sv
// Power-on / master-clear / power-fail sequencer with cascaded prescalers.
// Define POWSENSE_FILTER_EN to debounce powsense_n over FILT_CYCLES samples.
module power_clk_seq
    import cpu_timing_pkg::*;
#(
    parameter int POR_CYCLES  = DEF_POR_CYCLES,
    parameter int NCH         = 2,
    parameter int DIV_W       = 8,
    parameter int MCL_MIN     = DEF_MCL_MIN,
    parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
    input  logic                 sysclk,
    input  logic                 sys_rst,
    input  logic                 osc_ce,
    input  logic                 swmcl_n,
    input  logic                 opclcs,
    input  logic                 powsense_n,
    input  logic [NCH*DIV_W-1:0] div_i,
    output logic                 closc,
    output logic                 mcl,
    output logic                 powfail_n,
    output logic                 por_done,
    output logic [NCH-1:0]       tick_o,
    output logic [1:0]           state_o
);

    localparam int PW = cnt_w(POR_CYCLES);
    localparam int MW = cnt_w(MCL_MIN);

    logic [1:0] sync_q;
    logic       pwr_ok;

    always_ff @(posedge sysclk) begin
        if (sys_rst) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], powsense_n};
    end

`ifdef POWSENSE_FILTER_EN
    localparam int FW = cnt_w(FILT_CYCLES);

    logic [FW-1:0] filt_cnt_q;
    logic          filt_q;

    // Level flips only after FILT_CYCLES consecutive opposite samples
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else if (sync_q[1] == filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FW'(FILT_CYCLES - 1)) begin
            filt_q     <= sync_q[1];
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + FW'(1);
        end
    end

    assign pwr_ok = filt_q;
`else
    logic unused_filt;
    assign unused_filt = (FILT_CYCLES != 0);
    assign pwr_ok      = sync_q[1];
`endif

    state_e        state_q, state_d;
    logic [PW-1:0] por_cnt_q, por_cnt_d;
    logic [MW-1:0] str_q, str_d;
    logic          clr_req;
    logic          closc_q, closc_d;
    logic          mcl_q, mcl_d;
    logic          pfn_q, pfn_d;
    logic          done_q, done_d;

    assign clr_req = !swmcl_n || opclcs;

    always_comb begin
        state_d   = state_q;
        por_cnt_d = '0;
        str_d     = str_q;
        unique case (state_q)
            ST_POR: begin
                if (por_cnt_q == PW'(POR_CYCLES - 1)) state_d = ST_RUN;
                else por_cnt_d = por_cnt_q + PW'(1);
            end
            ST_RUN: begin
                if (clr_req) begin
                    state_d = ST_MCLR;
                    str_d   = MW'(MCL_MIN - 1);
                end
            end
            ST_MCLR: begin
                if (str_q != '0)  str_d   = str_q - MW'(1);
                else if (!clr_req) state_d = ST_RUN;
            end
            ST_PFAIL: begin
                if (pwr_ok) state_d = ST_POR;
            end
            default: state_d = ST_POR;
        endcase
        // Power fail overrides any clear request
        if (!pwr_ok && (state_q != ST_PFAIL)) state_d = ST_PFAIL;
    end

    always_comb begin
        closc_d = 1'b1;
        mcl_d   = 1'b1;
        pfn_d   = 1'b1;
        done_d  = 1'b0;
        unique case (state_d)
            ST_RUN: begin
                closc_d = 1'b0;
                mcl_d   = 1'b0;
                done_d  = 1'b1;
            end
            ST_MCLR: begin
                closc_d = 1'b0;
                done_d  = 1'b1;
            end
            ST_PFAIL: pfn_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            state_q   <= ST_POR;
            por_cnt_q <= '0;
            str_q     <= '0;
            closc_q   <= 1'b1;
            mcl_q     <= 1'b1;
            pfn_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            por_cnt_q <= por_cnt_d;
            str_q     <= str_d;
            closc_q   <= closc_d;
            mcl_q     <= mcl_d;
            pfn_q     <= pfn_d;
            done_q    <= done_d;
        end
    end

    logic [NCH-1:0] tick_w;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic ev;
        if (i == 0) begin : g_src0
            assign ev = osc_ce;
        end else begin : g_srcn
            assign ev = tick_w[i-1];
        end
        clk_prescaler #(.DIV_W(DIV_W)) u_pre (
            .clk_i  (sysclk),
            .rst_i  (sys_rst),
            .clr_i  (closc_q),
            .ev_i   (ev),
            .div_i  (div_i[i*DIV_W +: DIV_W]),
            .tick_o (tick_w[i])
        );
    end

    assign closc     = closc_q;
    assign mcl       = mcl_q;
    assign powfail_n = pfn_q;
    assign por_done  = done_q;
    assign tick_o    = tick_w;
    assign state_o   = state_q;

endmodule

// File: tb/tb_power_clk_seq.sv
// Directed/randomised bench for power_clk_seq with an event-count reference.
// Honours POWSENSE_FILTER_EN for expected power-sense latencies.
module tb_power_clk_seq;

    localparam int P  = 20;
    localparam int M  = 16;
    localparam int F  = 8;
    localparam int DW = 8;
    localparam int N  = 2;
`ifdef POWSENSE_FILTER_EN
    localparam int THR = F;
    localparam int LAT = F + 2;
`else
    localparam int THR = 1;
    localparam int LAT = 2;
`endif

    logic          sysclk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          osc_ce = 1'b0;
    logic          swmcl_n = 1'b1;
    logic          opclcs = 1'b0;
    logic          powsense_n = 1'b1;
    logic [N*DW-1:0] div_i = {8'd4, 8'd3};
    logic          closc, mcl, powfail_n, por_done;
    logic [N-1:0]  tick_o;
    logic [1:0]    state_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 sysclk = ~sysclk;

    power_clk_seq #(
        .POR_CYCLES (P),
        .NCH        (N),
        .DIV_W      (DW),
        .MCL_MIN    (M),
        .FILT_CYCLES(F)
    ) dut (
        .sysclk    (sysclk),
        .sys_rst   (sys_rst),
        .osc_ce    (osc_ce),
        .swmcl_n   (swmcl_n),
        .opclcs    (opclcs),
        .powsense_n(powsense_n),
        .div_i     (div_i),
        .closc     (closc),
        .mcl       (mcl),
        .powfail_n (powfail_n),
        .por_done  (por_done),
        .tick_o    (tick_o),
        .state_o   (state_o)
    );

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        step();
        step();
        sys_rst = 1'b0;
    endtask

    // Stops on the cycle por_done rises so the prescaler phase is known
    task automatic wait_por(input string tag);
        int rise = -1;
        int fall = -1;
        for (int i = 1; i <= P + 10; i++) begin
            step();
            if (rise < 0 && por_done === 1'b1) rise = i;
            if (fall < 0 && closc === 1'b0) fall = i;
            if (rise >= 0) break;
        end
        chk({tag, "_done_cyc"}, rise, P);
        chk({tag, "_closc_cyc"}, fall, P);
    endtask

    // Tick k of a channel fires on every div-th qualifying event
    task automatic run_cascade(input int d0, input int d1,
                               input int ncyc, input bit dense);
        int tot0 = 0;
        int tot1 = 0;
        bit e0 = 1'b0;
        bit e1 = 1'b0;
        bit p0;
        bit oce;
        for (int c = 0; c < ncyc; c++) begin
            oce = dense ? 1'b1 : 1'($urandom_range(0, 1));
            osc_ce = oce;
            p0 = e0;
            step();
            e0 = 1'b0;
            if (oce && d0 != 0) begin
                tot0++;
                e0 = (tot0 % d0 == 0);
            end
            e1 = 1'b0;
            if (p0 && d1 != 0) begin
                tot1++;
                e1 = (tot1 % d1 == 0);
            end
            chk("cascade_tick", tick_o, {e1, e0});
        end
    endtask

    task automatic run_clear(input bit use_op, input int len);
        int hi = 0;
        int endc = -1;
        int want = (len > M) ? len : M;
        if (use_op) opclcs = 1'b1;
        else swmcl_n = 1'b0;
        for (int i = 1; i <= len + M + 8; i++) begin
            step();
            if (i == 1) begin
                chk("mcl_rise", mcl, 1);
                chk("mclr_state", state_o, 2);
                chk("mclr_closc", closc, 0);
            end
            if (mcl === 1'b1) hi++;
            else if (endc < 0) endc = i;
            if (i == len) begin
                opclcs = 1'b0;
                swmcl_n = 1'b1;
            end
        end
        chk("mcl_len", hi, want);
        chk("mcl_fall", endc, want + 1);
        chk("clr_run_again", state_o, 1);
    endtask

    task automatic run_pf(input int g);
        int ent = -1;
        int rec = -1;
        int run = -1;
        bit hit = (g >= THR);
        powsense_n = 1'b0;
        for (int i = 1; i <= g + 1 + LAT + P + 8; i++) begin
            step();
            if (i == g) powsense_n = 1'b1;
            if (ent < 0 && powfail_n === 1'b0) begin
                ent = i;
                chk("pf_mcl", mcl, 1);
                chk("pf_closc", closc, 1);
                chk("pf_state", state_o, 3);
            end
            if (ent >= 0 && rec < 0 && powfail_n === 1'b1
                && state_o === 2'd0) rec = i;
            if (rec >= 0 && run < 0 && por_done === 1'b1) run = i;
        end
        chk("pf_entry", ent, hit ? 1 + LAT : -1);
        chk("pf_recover", rec, hit ? g + 1 + LAT : -1);
        chk("pf_run", run, hit ? g + 1 + LAT + P : -1);
        chk("pf_end_state", state_o, 1);
    endtask

    initial begin
        int d0, d1, first, run;

        step();
        step();
        step();
        chk("rst_closc", closc, 1);
        chk("rst_mcl", mcl, 1);
        chk("rst_powfail_n", powfail_n, 1);
        chk("rst_por_done", por_done, 0);
        chk("rst_tick", tick_o, 0);
        chk("rst_state", state_o, 0);

        osc_ce = 1'b1;
        sys_rst = 1'b0;
        wait_por("por");
        chk("por_state", state_o, 1);
        run_cascade(3, 4, 40, 1'b1);

        for (int t = 0; t < 3; t++) begin
            d0 = $urandom_range(1, 5);
            d1 = $urandom_range(1, 4);
            div_i = {8'(d1), 8'(d0)};
            do_reset();
            wait_por("por_rand");
            run_cascade(d0, d1, 60, t[0]);
        end

        div_i = {8'd4, 8'd0};
        osc_ce = 1'b1;
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            osc_ce = 1'($urandom_range(0, 1));
            step();
            chk("zero_div_tick", tick_o, 0);
        end
        div_i = {8'd4, 8'd4};
        osc_ce = 1'b1;
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (first < 0 && tick_o[0] === 1'b1) first = i;
        end
        chk("div_restore", first, 4);
        osc_ce = 1'b0;

        run_clear(1'b0, 2);
        step();
        run_clear(1'b1, 30);
        step();
        run_clear(1'b0, $urandom_range(1, 24));
        step();
        run_clear(1'b1, $urandom_range(1, 40));
        step();

        run_pf(5);
        run_pf(10);
        run_pf($urandom_range(1, 2 * F));

        powsense_n = 1'b0;
        for (int i = 1; i <= LAT; i++) step();
        chk("sim_pre_state", state_o, 1);
        opclcs = 1'b1;
        step();
        chk("sim_state", state_o, 3);
        chk("sim_powfail_n", powfail_n, 0);
        opclcs = 1'b0;
        powsense_n = 1'b1;
        run = -1;
        for (int i = 1; i <= LAT + P + 10; i++) begin
            step();
            if (run < 0 && por_done === 1'b1) run = i;
        end
        chk("sim_run", run, LAT + 1 + P);

        swmcl_n = 1'b0;
        step();
        chk("mid_mclr", state_o, 2);
        sys_rst = 1'b1;
        step();
        chk("mid_rst_state", state_o, 0);
        chk("mid_rst_mcl", mcl, 1);
        chk("mid_rst_closc", closc, 1);
        chk("mid_rst_done", por_done, 0);
        swmcl_n = 1'b1;
        sys_rst = 1'b0;
        wait_por("por_mid");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
